// File: rtl/alu_pwr_seq.sv
// Power-sequencing controller for the ALU power domain: drain, isolate, save and
// power off on request; power on, settle, restore and de-isolate on wake-up.
module alu_pwr_seq #(
    parameter int unsigned ISO_SETUP_CYCLES = 2,
    parameter int unsigned PU_SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pd_req,
    input  logic       pu_req,
    input  logic       alu_busy,
    output logic       alu_pwr_en,
    output logic       iso_en,
    output logic       save,
    output logic       restore,
    output logic       alu_ready,
    output logic       pd_done,
    output logic       pu_done,
    output logic [2:0] pwr_state
);

    typedef enum logic [2:0] {
        ST_ON      = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_ISO     = 3'd2,
        ST_SAVE    = 3'd3,
        ST_OFF     = 3'd4,
        ST_WAKE    = 3'd5,
        ST_RESTORE = 3'd6
    } state_t;

    typedef struct packed {
        logic pwr_en;
        logic iso;
        logic save;
        logic restore;
        logic ready;
    } ctrl_t;

    localparam logic [7:0] ISO_LAST = 8'(ISO_SETUP_CYCLES);
    localparam logic [7:0] PU_LAST  = 8'(PU_SETTLE_CYCLES);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    ctrl_t      ctrl_q;
    logic       pd_done_q;
    logic       pu_done_q;

    // Domain control values for a given state; applied to the next state so
    // every output leaves a flop in the same cycle the state changes.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_ON:      c = '{pwr_en: 1'b1, iso: 1'b0, save: 1'b0, restore: 1'b0, ready: 1'b1};
            ST_DRAIN:   c = '{pwr_en: 1'b1, iso: 1'b0, save: 1'b0, restore: 1'b0, ready: 1'b0};
            ST_ISO:     c = '{pwr_en: 1'b1, iso: 1'b1, save: 1'b0, restore: 1'b0, ready: 1'b0};
            ST_SAVE:    c = '{pwr_en: 1'b1, iso: 1'b1, save: 1'b1, restore: 1'b0, ready: 1'b0};
            ST_OFF:     c = '{pwr_en: 1'b0, iso: 1'b1, save: 1'b0, restore: 1'b0, ready: 1'b0};
            ST_WAKE:    c = '{pwr_en: 1'b1, iso: 1'b1, save: 1'b0, restore: 1'b0, ready: 1'b0};
            ST_RESTORE: c = '{pwr_en: 1'b1, iso: 1'b1, save: 1'b0, restore: 1'b1, ready: 1'b0};
            default:    c = '{pwr_en: 1'b1, iso: 1'b0, save: 1'b0, restore: 1'b0, ready: 1'b1};
        endcase
        return c;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = 8'd0;
        case (state_q)
            ST_ON: begin
                if (pd_req) begin
                    if (alu_busy) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_ISO;
                        cnt_d   = 8'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!alu_busy) begin
                    state_d = ST_ISO;
                    cnt_d   = 8'd1;
                end
            end
            ST_ISO: begin
                if (cnt_q == ISO_LAST) begin
                    state_d = ST_SAVE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SAVE: begin
                state_d = ST_OFF;
            end
            ST_OFF: begin
                if (pu_req) begin
                    state_d = ST_WAKE;
                    cnt_d   = 8'd1;
                end
            end
            ST_WAKE: begin
                if (cnt_q == PU_LAST) begin
                    state_d = ST_RESTORE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESTORE: begin
                state_d = ST_ON;
            end
            default: begin
                state_d = ST_ON;
            end
        endcase
    end

    // NOTE: state and outputs use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ON;
            cnt_q     <= 8'd0;
            ctrl_q    <= decode(ST_ON);
            pd_done_q <= 1'b0;
            pu_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= decode(state_d);
            pd_done_q <= (state_d == ST_OFF) && (state_q != ST_OFF);
            pu_done_q <= (state_d == ST_ON) && (state_q == ST_RESTORE);
        end
    end

    assign alu_pwr_en = ctrl_q.pwr_en;
    assign iso_en     = ctrl_q.iso;
    assign save       = ctrl_q.save;
    assign restore    = ctrl_q.restore;
    assign alu_ready  = ctrl_q.ready;
    assign pd_done    = pd_done_q;
    assign pu_done    = pu_done_q;
    assign pwr_state  = state_q;

endmodule
